// File: rtl/mme_top.sv
// 4x4 result matrix-multiply engine: C = A(4xN) x B(Nx4), signed 32-bit wrap-around.
// APB-programmed, fetches one A column and one B row per k over AXI, writes C as one 16-beat burst.
module mme_top #(
    parameter logic [31:0] IP_VERSION = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] paddr_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [3:0]  bid_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o
);

    localparam logic [31:0] ADDR_VER    = 32'h000;
    localparam logic [31:0] ADDR_CFG    = 32'h100;
    localparam logic [31:0] ADDR_A      = 32'h200;
    localparam logic [31:0] ADDR_B      = 32'h204;
    localparam logic [31:0] ADDR_C      = 32'h208;
    localparam logic [31:0] ADDR_CMD    = 32'h20C;
    localparam logic [31:0] ADDR_STATUS = 32'h210;

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR_ADDR, WR_DATA, WR_RESP} state_e;

    state_e      state_q;
    logic [31:0] cfg_q, a_addr_q, b_addr_q, c_addr_q;
    logic        done_q;
    logic [7:0]  n_q, k_q;
    logic [31:0] a_base_q, b_base_q, c_base_q;
    logic [31:0] avec_q [4];
    logic [31:0] bvec_q [4];
    logic [31:0] acc_q  [4][4];
    logic [31:0] mac_d  [4][4];
    logic [3:0]  beat_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [31:0] araddr_q, wdata_q;

    logic        apb_wr, start;
    logic [3:0]  beat_nx;
    logic [7:0]  k_nx;
    logic        unused_inputs;

    assign apb_wr  = psel_i && penable_i && pwrite_i;
    assign start   = apb_wr && (paddr_i == ADDR_CMD) && pwdata_i[0] && (state_q == IDLE);
    assign beat_nx = beat_q + 4'd1;
    assign k_nx    = k_q + 8'd1;
    assign unused_inputs = ^{rid_i, rresp_i, rlast_i, bid_i, bresp_i};

    always_comb begin
        for (int unsigned r = 0; r < 4; r++)
            for (int unsigned c = 0; c < 4; c++)
                mac_d[r][c] = acc_q[r][c] + avec_q[r] * bvec_q[c];
    end

    always_comb begin
        prdata_o = '0;
        if (psel_i && !rst_n) begin
            case (paddr_i)
                ADDR_VER:    prdata_o = IP_VERSION;
                ADDR_CFG:    prdata_o = cfg_q;
                ADDR_A:      prdata_o = a_addr_q;
                ADDR_B:      prdata_o = b_addr_q;
                ADDR_C:      prdata_o = c_addr_q;
                ADDR_STATUS: prdata_o = {31'd0, done_q};
                default:     prdata_o = '0;
            endcase
        end
    end

    assign pready_o  = !rst_n;
    assign pslverr_o = 1'b0;
    assign arid_o    = '0;
    assign araddr_o  = araddr_q;
    assign arlen_o   = 4'd3;
    assign arsize_o  = 3'd2;
    assign arburst_o = 2'b01;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign awid_o    = '0;
    assign awaddr_o  = c_base_q;
    assign awlen_o   = 4'd15;
    assign awsize_o  = 3'd2;
    assign awburst_o = 2'b01;
    assign awvalid_o = awvalid_q;
    assign wid_o     = '0;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = '1;
    assign wlast_o   = wlast_q;
    assign wvalid_o  = wvalid_q;
    assign bready_o  = bready_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            c_addr_q  <= '0;
            done_q    <= 1'b0;
            n_q       <= '0;
            k_q       <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            c_base_q  <= '0;
            beat_q    <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                avec_q[i] <= '0;
                bvec_q[i] <= '0;
                for (int unsigned j = 0; j < 4; j++) acc_q[i][j] <= '0;
            end
        end else begin
            if (apb_wr) begin
                case (paddr_i)
                    ADDR_CFG: cfg_q    <= pwdata_i;
                    ADDR_A:   a_addr_q <= pwdata_i;
                    ADDR_B:   b_addr_q <= pwdata_i;
                    ADDR_C:   c_addr_q <= pwdata_i;
                    default:  ;
                endcase
            end

            case (state_q)
                IDLE: if (start) begin
                    done_q   <= 1'b0;
                    n_q      <= cfg_q[7:0];
                    k_q      <= '0;
                    a_base_q <= a_addr_q;
                    b_base_q <= b_addr_q;
                    c_base_q <= c_addr_q;
                    beat_q   <= '0;
                    for (int unsigned i = 0; i < 4; i++)
                        for (int unsigned j = 0; j < 4; j++) acc_q[i][j] <= '0;
                    if (cfg_q[7:0] == 8'd0) begin
                        awvalid_q <= 1'b1;
                        state_q   <= WR_ADDR;
                    end else begin
                        araddr_q  <= a_addr_q;
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                        state_q   <= RD_A;
                    end
                end
                RD_A: begin
                    if (arvalid_q && arready_i) arvalid_q <= 1'b0;
                    if (rvalid_i) begin
                        avec_q[beat_q[1:0]] <= rdata_i;
                        beat_q <= beat_nx;
                        if (beat_q == 4'd3) begin
                            beat_q    <= '0;
                            araddr_q  <= b_base_q + {20'd0, k_q, 4'd0};
                            arvalid_q <= 1'b1;
                            state_q   <= RD_B;
                        end
                    end
                end
                RD_B: begin
                    if (arvalid_q && arready_i) arvalid_q <= 1'b0;
                    if (rvalid_i) begin
                        bvec_q[beat_q[1:0]] <= rdata_i;
                        beat_q <= beat_nx;
                        if (beat_q == 4'd3) begin
                            beat_q   <= '0;
                            rready_q <= 1'b0;
                            state_q  <= MAC;
                        end
                    end
                end
                MAC: begin
                    acc_q <= mac_d;
                    if (k_nx == n_q) begin
                        awvalid_q <= 1'b1;
                        state_q   <= WR_ADDR;
                    end else begin
                        k_q       <= k_nx;
                        araddr_q  <= a_base_q + {20'd0, k_nx, 4'd0};
                        arvalid_q <= 1'b1;
                        rready_q  <= 1'b1;
                        state_q   <= RD_A;
                    end
                end
                WR_ADDR: if (awready_i) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    wdata_q   <= acc_q[0][0];
                    wlast_q   <= 1'b0;
                    beat_q    <= '0;
                    state_q   <= WR_DATA;
                end
                WR_DATA: if (wready_i) begin
                    if (beat_q == 4'd15) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else begin
                        beat_q  <= beat_nx;
                        wdata_q <= acc_q[beat_nx[3:2]][beat_nx[1:0]];
                        wlast_q <= (beat_q == 4'd14);
                    end
                end
                WR_RESP: if (bvalid_i) begin
                    bready_q <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mme_top.sv
// Bench for mme_top: AXI memory slave with optional stalls and an integer reference matrix product.
module tb_mme_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [3:0]  arid_o, arlen_o, awid_o, awlen_o, wid_o, wstrb_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o;
    logic        arvalid_o, rready_o, awvalid_o, wlast_o, wvalid_o, bready_o;
    logic        arready_i = 1'b0, rlast_i = 1'b0, rvalid_i = 1'b0;
    logic        awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0, bresp_i = '0;

    always #5 clk = ~clk;

    mme_top #(.IP_VERSION(32'h0001_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .paddr_i(paddr), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(4'd0), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(4'd0), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    int checks = 0;
    int failures = 0;
    bit stall_en = 1'b0;
    logic [31:0] mem [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] addr);
        return int'((addr >> 2) & 32'hFFF);
    endfunction

    // AXI memory slave: handshakes sampled at posedge, responses driven at negedge
    bit          rd_act = 1'b0, aw_ok = 1'b0, b_pend = 1'b0, w_hold = 1'b0;
    logic [31:0] rd_addr = '0, wr_base = '0, w_hold_data = '0;
    int          rd_beat = 0, wr_beat = 0;
    bit          r_hs, b_hs;

    always begin
        @(posedge clk);
        r_hs = 1'b0;
        b_hs = 1'b0;
        if (!rst_n) begin
            if (w_hold) chk("w_stable", wdata_o, w_hold_data);
            w_hold      = wvalid_o && !wready_i;
            w_hold_data = wdata_o;
            if (rvalid_i && rready_o) begin
                r_hs = 1'b1;
                rd_beat++;
                if (rd_beat == 4) rd_act = 1'b0;
            end
            if (arvalid_o && arready_i) begin
                chk("ar_single_outstanding", {31'd0, rd_act}, 32'd0);
                chk("ar_fields", {arid_o, arlen_o, 1'b0, arsize_o, 2'b0, arburst_o}, {4'd0, 4'd3, 1'b0, 3'd2, 2'b0, 2'b01});
                rd_act  = 1'b1;
                rd_addr = araddr_o;
                rd_beat = 0;
            end
            if (awvalid_o && awready_i) begin
                chk("aw_fields", {awlen_o, 1'b0, awsize_o, 2'b0, awburst_o}, {4'd15, 1'b0, 3'd2, 2'b0, 2'b01});
                aw_ok   = 1'b1;
                wr_base = awaddr_o;
                wr_beat = 0;
            end
            if (wvalid_o && wready_i) begin
                chk("w_after_aw", {31'd0, aw_ok}, 32'd1);
                chk("wlast", {31'd0, wlast_o}, {31'd0, wr_beat == 15});
                chk("wstrb", {28'd0, wstrb_o}, 32'hF);
                mem[(widx(wr_base) + wr_beat) & 4095] = wdata_o;
                wr_beat++;
                if (wr_beat == 16) begin
                    b_pend = 1'b1;
                    aw_ok  = 1'b0;
                end
            end
            if (bvalid_i && bready_o) begin
                b_hs   = 1'b1;
                b_pend = 1'b0;
            end
        end
        @(negedge clk);
        if (rst_n) begin
            rd_act = 1'b0; aw_ok = 1'b0; b_pend = 1'b0; w_hold = 1'b0;
            arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0;
            awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
        end else begin
            arready_i = !stall_en || ($urandom_range(0, 2) != 0);
            awready_i = !stall_en || ($urandom_range(0, 2) != 0);
            wready_i  = !stall_en || ($urandom_range(0, 2) != 0);
            rvalid_i  = rd_act && (!stall_en || ($urandom_range(0, 2) != 0) || (rvalid_i && !r_hs));
            rdata_i   = mem[(widx(rd_addr) + rd_beat) & 4095];
            rlast_i   = (rd_beat == 3);
            rresp_i   = stall_en ? 2'($urandom_range(0, 3)) : 2'b00;
            bvalid_i  = b_pend && (!stall_en || ($urandom_range(0, 2) != 0) || (bvalid_i && !b_hs));
            bresp_i   = stall_en ? 2'($urandom_range(0, 3)) : 2'b00;
        end
    end

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata_o;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(tag, d, exp);
    endtask

    // A at 0x0 (column-major), B at 0x1000 (row-major), results expected at 0x2000
    task automatic run_case(input int n, input bit full, input bit poke_busy);
        int av [4][16];
        int bv [16][4];
        int s;
        int polls;
        logic [31:0] d;
        for (int k = 0; k < n; k++)
            for (int i = 0; i < 4; i++) begin
                av[i][k] = full ? int'($urandom) : int'($urandom_range(0, 255));
                bv[k][i] = full ? int'($urandom) : int'($urandom_range(0, 255));
                mem[widx(32'h0000 + 32'(4 * (4 * k + i)))] = av[i][k];
                mem[widx(32'h1000 + 32'(4 * (4 * k + i)))] = bv[k][i];
            end
        for (int i = 0; i < 16; i++) mem[widx(32'h2000) + i] = 32'hDEAD_BEEF;
        apb_write(32'h100, 32'(n));
        apb_write(32'h20C, 32'h1);
        apb_read(32'h210, d);
        chk($sformatf("status_busy_n%0d", n), d, 32'd0);
        if (poke_busy) begin
            apb_write(32'h208, 32'h2800);
            apb_write(32'h20C, 32'h1);
        end
        polls = 0;
        do begin
            apb_read(32'h210, d);
            polls++;
        end while (d[0] == 1'b0 && polls < 3000);
        chk($sformatf("status_done_n%0d", n), d, 32'd1);
        if (poke_busy) apb_write(32'h208, 32'h2000);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < n; k++) s += av[r][k] * bv[k][c];
                chk($sformatf("C[%0d][%0d]_n%0d", r, c, n), mem[widx(32'h2000) + 4 * r + c], s);
            end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_valids"}, {28'd0, arvalid_o, awvalid_o, wvalid_o, 1'b0}, 32'd0);
        chk({tag, "_readies"}, {29'd0, rready_o, bready_o, pready_o}, 32'd0);
        chk({tag, "_apb"}, prdata_o | {31'd0, pslverr_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b0;

        rd_chk("ip_ver", 32'h000, 32'h0001_0000);
        apb_write(32'h300, 32'hFFFF_FFFF);
        rd_chk("unmapped", 32'h300, 32'd0);
        apb_write(32'h100, 32'd4);
        apb_write(32'h200, 32'h0);
        apb_write(32'h204, 32'h1000);
        apb_write(32'h208, 32'h2000);
        rd_chk("cfg_rb", 32'h100, 32'd4);
        rd_chk("a_rb", 32'h200, 32'h0);
        rd_chk("b_rb", 32'h204, 32'h1000);
        rd_chk("c_rb", 32'h208, 32'h2000);
        rd_chk("cmd_rb", 32'h20C, 32'd0);
        chk("pslverr", {31'd0, pslverr_o}, 32'd0);

        run_case(4, 1'b0, 1'b0);
        run_case(8, 1'b0, 1'b1);
        run_case(12, 1'b0, 1'b0);
        run_case(16, 1'b0, 1'b0);
        stall_en = 1'b1;
        run_case(3, 1'b1, 1'b0);
        run_case(5, 1'b0, 1'b0);

        apb_write(32'h100, 32'd16);
        apb_write(32'h20C, 32'h1);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk_idle_outputs("midrun_reset");
        repeat (3) begin
            @(negedge clk);
            #1 chk("reset_quiet", {29'd0, arvalid_o, awvalid_o, wvalid_o}, 32'd0);
        end
        rst_n = 1'b0;
        rd_chk("cfg_after_reset", 32'h100, 32'd0);
        rd_chk("c_after_reset", 32'h208, 32'd0);
        rd_chk("status_after_reset", 32'h210, 32'd0);
        apb_write(32'h200, 32'h0);
        apb_write(32'h204, 32'h1000);
        apb_write(32'h208, 32'h2000);
        run_case(4, 1'b0, 1'b0);
        run_case(0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mme_top.md
# mme_top

Matrix-multiply engine: computes C(4x4) = A(4xN) x B(Nx4) on signed 32-bit integers, with N programmable. Sits as an APB-configured peripheral with an AXI master port to system memory. It fetches A and B, accumulates the products internally, writes C back to memory, and flags completion in a status register.

## Interface

**Parameters**
- `IP_VERSION`, default 32'h0001_0000: value returned by the IP_VER register.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-high.
- `apb_if`, APB slave bundle:
  - `paddr[31:0]`, `psel`, `penable`, `pwrite`, `pwdata[31:0]` are inputs.
  - `prdata[31:0]`, `pready`, `pslverr` are outputs.
- `axi_ar_if`, AXI AR master, outputs: `arid[3:0]`, `araddr[31:0]`, `arlen[3:0]`, `arsize[2:0]`, `arburst[1:0]`, `arvalid`. Input: `arready`.
- `axi_r_if`, AXI R: `rid`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rvalid` are inputs. Output: `rready`.
- `axi_aw_if`, AXI AW master, same fields as AR with an `aw` prefix.
- `axi_w_if`, AXI W, outputs: `wid[3:0]`, `wdata[31:0]`, `wstrb[3:0]`, `wlast`, `wvalid`. Input: `wready`.
- `axi_b_if`, AXI B: `bid`, `bresp[1:0]`, `bvalid` are inputs. Output: `bready`.

## Operation

**Register map** (APB byte offsets):
- 0x000 IP_VER: read-only, returns `IP_VERSION`.
- 0x100 MAT_CFG: read/write, 32 bits. Bits [7:0] give N.
- 0x200 MAT_A_ADDR: read/write, 32 bits.
- 0x204 MAT_B_ADDR: read/write, 32 bits.
- 0x208 MAT_C_ADDR: read/write, 32 bits.
- 0x20C MME_CMD: writing bit0=1 starts a run. Reads return 0.
- 0x210 MME_STATUS: read-only, bit0 = done.
- Unmapped offsets read as 0; writes to them are ignored. `pslverr` is always 0.
- Read/write registers read back exactly what was written. Values are sampled at start; writes during a run do not affect that run.

**Memory layout:**
- A is column-major: A[r][k] is at A_ADDR + 4·(4k + r).
- B is row-major: B[k][c] is at B_ADDR + 4·(4k + c).
- C is row-major: C[r][c] is at C_ADDR + 4·(4r + c).

**Run sequence.** FSM states are IDLE, RD_A, RD_B, MAC, WR_ADDR, WR_DATA, WR_RESP. For each k from 0 to N-1:
- RD_A: issue one 4-beat INCR read at A_ADDR + 16k (arlen=3, arsize=2, arburst=INCR, arid=0). Capture 4 words.
- RD_B: issue one 4-beat INCR read at B_ADDR + 16k. Capture 4 words.
- MAC: perform 16 parallel updates, acc[r][c] += A[r]·B[c]. This is signed 32x32 multiplication, truncated to 32 bits, with wrap-around accumulation.

After k = N-1:
- WR_ADDR: issue one 16-beat INCR write at C_ADDR (awlen=15).
- WR_DATA: stream acc row-major, wstrb=4'hF, wlast on beat 16.
- WR_RESP: wait for B, then set done and return to IDLE.

**Start and done rules:**
- A start command clears done and all 16 accumulators.
- A start while busy is ignored.
- N=0 skips all reads and writes 16 zeros.
- `rresp` and `bresp` errors are ignored; the run still completes.

## Timing

- **APB:** zero-wait (`pready`=1).
  - Write takes effect on the clock edge where psel & penable & pwrite.
  - `prdata` is valid combinationally in the access phase.
  - Status reads 0 from the cycle after the CMD write until completion.
- **AXI handshakes:**
  - `arvalid`/`awvalid` are held until the ready handshake and do not depend on ready.
  - `rready` is 1 in RD_A/RD_B. `bready` is 1 in WR_RESP.
  - `wvalid` is held with stable data until `wready`.
  - AW and W are serialized: W starts only after the AW handshake.
  - One outstanding transaction at a time.
- MAC is one cycle per k.
- Done is set in the cycle after the B handshake. It stays 1 until the next start or reset.
- **Reset values:**
  - All `*valid`/`*ready` outputs are 0.
  - `prdata` is 0 and `pslverr` is 0.
  - All registers, done, and accumulators are 0. FSM is in IDLE.
  - Reset mid-run aborts immediately with no further AXI activity.

## Test plan

- Read 0x000 -> `IP_VERSION`.
- Write then read back MAT_CFG=4, A=0x0, B=0x1000, C=0x2000 -> readback exact. MME_CMD reads 0.
- N=4 with random A,B in 0..255, start, poll status -> done=1. Memory at 0x2000..0x203C equals A·B, low 32 bits, row-major.
- Repeat with N=8, 12, 16 back-to-back without reset -> status drops to 0 after each start and all 16 outputs match.
- Apply AXI slave ready/valid stalls, then assert reset mid-run -> outputs return to reset values and a subsequent N=4 run passes.
- N=0 -> 16 zero words written, done=1.
